// File: rtl/bus_pkg.sv
// Shared bus constants: copy-master state encoding, element strides and the
// address map values also used by the bus decoder.
package bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    READ   = ST_READ,
    WRITE  = ST_WRITE,
    FINISH = ST_FINISH
  } state_e;

  localparam logic [31:0] WORD_STRIDE   = 32'd4;
  localparam logic [31:0] BYTE_STRIDE   = 32'd1;
  localparam logic [31:0] DM_ADDR_LIMIT = 32'h4000_0000;
  localparam logic [31:0] BCD_ADDR      = 32'h4000_0010;

  // Address increment between consecutive elements.
  function automatic logic [31:0] elem_stride(input logic byte_mode);
    return byte_mode ? BYTE_STRIDE : WORD_STRIDE;
  endfunction

endpackage

// File: rtl/bus_copy_addr_gen.sv
// Address generator for the copy master: source/destination pointers,
// element countdown, and the start-time alignment/range check.
module bus_copy_addr_gen
  import bus_pkg::*;
#(
  parameter int          LEN_W      = 16,
  parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step_src,
  input  logic             step_dst,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             byte_mode,
  output logic [31:0]      cur_src,
  output logic [31:0]      cur_dst,
  output logic [LEN_W-1:0] remaining,
  output logic             byte_mode_q,
  output logic             reject
);

  logic [LEN_W-1:0] len_m1;
  logic [32:0]      span;
  logic [32:0]      src_last;
  logic [32:0]      dst_last;
  logic             misalign;

  // Reject check on the raw request; 33-bit sums so a wrap past 2^32 lands
  // above the limit. Meaningless for length 0, which the FSM handles first.
  always_comb begin
    len_m1   = length - LEN_W'(1);
    span     = byte_mode ? 33'(len_m1) : (33'(len_m1) << 2);
    src_last = {1'b0, src_addr} + span;
    dst_last = {1'b0, dst_addr} + span;
    misalign = !byte_mode && ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00));
    reject   = misalign
            || (src_last >= {1'b0, ADDR_LIMIT})
            || (dst_last >= {1'b0, ADDR_LIMIT});
  end

  // Pointers and count load on an accepted start, then advance per bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_src     <= '0;
      cur_dst     <= '0;
      remaining   <= '0;
      byte_mode_q <= 1'b0;
    end else if (load) begin
      cur_src     <= src_addr;
      cur_dst     <= dst_addr;
      remaining   <= length;
      byte_mode_q <= byte_mode;
    end else begin
      if (step_src) begin
        cur_src <= cur_src + elem_stride(byte_mode_q);
      end
      if (step_dst) begin
        cur_dst   <= cur_dst + elem_stride(byte_mode_q);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/bus_copy_master.sv
// Block-copy bus initiator: one read then one write per element, word or byte
// sized. Bus outputs are decoded purely from registered state.
module bus_copy_master
  import bus_pkg::*;
#(
  parameter int          LEN_W      = 16,
  parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             byte_mode,
  output logic             Write_enable,
  output logic             Read_enable,
  output logic             WordorByte,
  output logic [31:0]      Addr,
  output logic [31:0]      Write_data,
  input  logic [31:0]      Read_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] remaining
);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] buf_q;
  logic        load, step_src, step_dst;
  logic        reject, byte_mode_q;
  logic [31:0] cur_src, cur_dst;

  bus_copy_addr_gen #(
    .LEN_W      (LEN_W),
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step_src    (step_src),
    .step_dst    (step_dst),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .byte_mode   (byte_mode),
    .cur_src     (cur_src),
    .cur_dst     (cur_dst),
    .remaining   (remaining),
    .byte_mode_q (byte_mode_q),
    .reject      (reject)
  );

  // Next-state logic; abort wins over start in IDLE, and in READ/WRITE it
  // lets the current bus cycle complete before dropping straight to IDLE.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    load     = 1'b0;
    step_src = 1'b0;
    step_dst = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load = 1'b1;
          if (length == '0) begin
            err_d   = 1'b0;
            state_d = FINISH;
          end else if (reject) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            err_d   = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        step_src = 1'b1;
        state_d  = abort ? IDLE : WRITE;
      end
      WRITE: begin
        step_dst = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (remaining > LEN_W'(1)) begin
          state_d = READ;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, reject flag and the element buffer captured during READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == READ) begin
        buf_q <= byte_mode_q ? {24'h0, Read_data[7:0]} : Read_data;
      end
    end
  end

  // Bus and status outputs decoded from registered state only.
  always_comb begin
    Read_enable  = 1'b0;
    Write_enable = 1'b0;
    WordorByte   = 1'b0;
    Addr         = '0;
    Write_data   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (state_q)
      READ: begin
        Read_enable = 1'b1;
        WordorByte  = ~byte_mode_q;
        Addr        = cur_src;
        busy        = 1'b1;
      end
      WRITE: begin
        Write_enable = 1'b1;
        WordorByte   = ~byte_mode_q;
        Addr         = cur_dst;
        Write_data   = buf_q;
        busy         = 1'b1;
      end
      FINISH: begin
        done  = 1'b1;
        error = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Randomised bench for bus_copy_master with a byte-addressed memory slave and
// a sequential element-copy reference model.
module tb_bus_copy_master;

  localparam int          LEN_W = 16;
  localparam logic [31:0] LIMIT = 32'h4000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic             byte_mode = 1'b0;
  logic             Write_enable, Read_enable, WordorByte;
  logic [31:0]      Addr, Write_data;
  logic [31:0]      Read_data = '0;
  logic             busy, done, error;
  logic [LEN_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    bit          wob;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t        ops[$];
  op_t        exp_ops[$];
  logic [7:0] mem  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  always #5 clk = ~clk;

  bus_copy_master #(.LEN_W(LEN_W), .ADDR_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .byte_mode    (byte_mode),
    .Write_enable (Write_enable),
    .Read_enable  (Read_enable),
    .WordorByte   (WordorByte),
    .Addr         (Addr),
    .Write_data   (Write_data),
    .Read_data    (Read_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] grd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 32'(i)]  = w[8*i +: 8];
      gold[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Memory slave: logs every bus cycle, commits writes, and presents read
  // data well before the capturing edge. Byte reads carry junk above [7:0].
  always @(negedge clk) begin : bus_slave
    op_t o;
    Read_data = 32'h0;
    if (Read_enable) begin
      o.we = 1'b0; o.wob = WordorByte; o.addr = Addr; o.data = 32'h0;
      ops.push_back(o);
      Read_data = WordorByte ? {mrd(Addr + 32'd3), mrd(Addr + 32'd2), mrd(Addr + 32'd1), mrd(Addr)}
                             : {24'hDEADBE, mrd(Addr)};
    end
    if (Write_enable) begin
      o.we = 1'b1; o.wob = WordorByte; o.addr = Addr; o.data = Write_data;
      ops.push_back(o);
      if (WordorByte) begin
        for (int i = 0; i < 4; i++) mem[Addr + 32'(i)] = Write_data[8*i +: 8];
      end else begin
        mem[Addr] = Write_data[7:0];
      end
    end
  end

  // Reference: copy elements one at a time on the golden memory, producing
  // the expected bus cycles; stops after n_ops bus cycles.
  task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit bm, input int n_ops);
    op_t         o;
    logic [31:0] a_s, a_d, d, s;
    exp_ops.delete();
    s = bm ? 32'd1 : 32'd4;
    for (int i = 0; i < len && exp_ops.size() < n_ops; i++) begin
      a_s = src + 32'(i) * s;
      a_d = dst + 32'(i) * s;
      d = bm ? {24'h0, grd(a_s)}
             : {grd(a_s + 32'd3), grd(a_s + 32'd2), grd(a_s + 32'd1), grd(a_s)};
      o.we = 1'b0; o.wob = !bm; o.addr = a_s; o.data = 32'h0;
      exp_ops.push_back(o);
      if (exp_ops.size() < n_ops) begin
        o.we = 1'b1; o.wob = !bm; o.addr = a_d; o.data = d;
        exp_ops.push_back(o);
        if (bm) gold[a_d] = d[7:0];
        else for (int j = 0; j < 4; j++) gold[a_d + 32'(j)] = d[8*j +: 8];
      end
    end
  endtask

  task automatic check_ops_mem();
    int n, diffs;
    chk("op_count", 64'(ops.size()), 64'(exp_ops.size()));
    n = (ops.size() < exp_ops.size()) ? ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) begin
      chk("op_kind", {62'h0, ops[i].we, ops[i].wob}, {62'h0, exp_ops[i].we, exp_ops[i].wob});
      chk("op_addr", 64'(ops[i].addr), 64'(exp_ops[i].addr));
      chk("op_data", 64'(ops[i].data), 64'(exp_ops[i].data));
    end
    diffs = 0;
    foreach (gold[a]) if (mrd(a) !== gold[a]) diffs++;
    foreach (mem[a])  if (grd(a) !== mem[a])  diffs++;
    chk("mem_image", 64'(diffs), 64'h0);
  endtask

  // One transfer: start at edge 0, optional ignored restart at cycle
  // inject_at and optional abort at cycle abort_at.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit bm, input int inject_at, input int abort_at);
    longint unsigned s, last_s, last_d;
    bit   exp_err, aborted, got;
    int   nbus, n_ops, done_cyc;
    logic err_obs, busy_obs;
    s = bm ? 1 : 4;
    exp_err = 1'b0;
    if (len != 0) begin
      last_s = {32'h0, src} + longint'(len - 1) * s;
      last_d = {32'h0, dst} + longint'(len - 1) * s;
      exp_err = (!bm && (src[1:0] != 2'b00 || dst[1:0] != 2'b00))
             || last_s >= {32'h0, LIMIT} || last_d >= {32'h0, LIMIT};
    end
    nbus    = (len == 0 || exp_err) ? 0 : 2 * len;
    aborted = (abort_at > 0) && (abort_at <= nbus);
    n_ops   = aborted ? abort_at : nbus;
    model_xfer(src, dst, len, bm, n_ops);

    @(negedge clk);
    ops.delete();
    src_addr = src; dst_addr = dst; length = LEN_W'(len); byte_mode = bm;
    start = 1'b1; abort = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0; done_cyc = 0; err_obs = 1'b0; busy_obs = 1'b1;
    for (int k = 1; k <= nbus + 10; k++) begin
      @(negedge clk);
      if (k == 1 && nbus > 0) chk("busy_c1", 64'(busy), 64'h1);
      if (aborted && k == abort_at + 1)
        chk("abort_idle", {61'h0, busy, Read_enable, Write_enable}, 64'h0);
      if (done && !got) begin
        got = 1'b1; done_cyc = k; err_obs = error; busy_obs = busy;
      end
      if (got && !aborted) break;
      if (aborted && k == abort_at + 4) break;
      start = (k == inject_at);
      if (k == inject_at) begin
        src_addr = src ^ 32'h400;
        length   = LEN_W'(len + 3);
      end
      abort = (k == abort_at);
    end
    start = 1'b0; abort = 1'b0;

    if (aborted) begin
      chk("abort_nodone", 64'(got), 64'h0);
      chk("abort_rem", 64'(remaining), 64'(len - abort_at / 2));
    end else begin
      chk("done_cycle", 64'(done_cyc), 64'(nbus + 1));
      chk("error_flag", 64'(err_obs), 64'(exp_err));
      chk("busy_at_done", 64'(busy_obs), 64'h0);
      chk("rem_end", 64'(remaining), 64'((nbus > 0) ? 0 : len));
    end
    check_ops_mem();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] src, dst;
    int          len, inj, abt, seen;
    bit          bm;

    // Reset state
    #12;
    chk("rst_ctrl", {58'h0, Write_enable, Read_enable, WordorByte, busy, done, error}, 64'h0);
    chk("rst_addr", 64'(Addr), 64'h0);
    chk("rst_wdata", 64'(Write_data), 64'h0);
    chk("rst_rem", 64'(remaining), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int a = 0; a < 'h800; a++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem[32'(a)] = b;
      gold[32'(a)] = b;
    end
    put_word(32'h100, 32'hA1); put_word(32'h104, 32'hB2);
    put_word(32'h108, 32'hC3); put_word(32'h10C, 32'hD4);

    // Word copy
    run_xfer(32'h100, 32'h200, 4, 1'b0, 0, 0);
    chk("word_0x20C", 64'({mrd(32'h20F), mrd(32'h20E), mrd(32'h20D), mrd(32'h20C)}), 64'hD4);

    // Byte copy
    mem[32'h101] = 8'h11; mem[32'h102] = 8'h22; mem[32'h103] = 8'h33;
    gold[32'h101] = 8'h11; gold[32'h102] = 8'h22; gold[32'h103] = 8'h33;
    run_xfer(32'h101, 32'h302, 3, 1'b1, 0, 0);
    chk("byte_0x304", 64'(mrd(32'h304)), 64'h33);

    // Rejections and limit boundaries
    run_xfer(32'h102, 32'h200, 4, 1'b0, 0, 0);
    run_xfer(32'h100, 32'h3FFF_FFFC, 2, 1'b0, 0, 0);
    run_xfer(32'h100, 32'h3FFF_FFF8, 2, 1'b0, 0, 0);
    run_xfer(32'h3FFF_FFFF, 32'h300, 1, 1'b1, 0, 0);
    run_xfer(32'h3FFF_FFFF, 32'h300, 2, 1'b1, 0, 0);
    run_xfer(32'hFFFF_FFFC, 32'h300, 2, 1'b0, 0, 0);

    // Zero length and ignored restart while busy
    run_xfer(32'h100, 32'h200, 0, 1'b0, 0, 0);
    run_xfer(32'h100, 32'h400, 3, 1'b0, 2, 0);

    // Abort during the second WRITE
    run_xfer(32'h100, 32'h500, 4, 1'b0, 0, 4);

    // Abort together with start in IDLE
    @(negedge clk);
    ops.delete();
    src_addr = 32'h100; dst_addr = 32'h600; length = LEN_W'(2); byte_mode = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen += int'(busy) + int'(done);
    end
    chk("idle_abort_quiet", 64'(seen), 64'h0);
    chk("idle_abort_ops", 64'(ops.size()), 64'h0);

    // Asynchronous reset in the middle of the second READ
    model_xfer(32'h140, 32'h240, 4, 1'b0, 2);
    @(negedge clk);
    ops.delete();
    src_addr = 32'h140; dst_addr = 32'h240; length = LEN_W'(4); byte_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_ctrl", {58'h0, Write_enable, Read_enable, WordorByte, busy, done, error}, 64'h0);
    chk("arst_addr", 64'(Addr), 64'h0);
    chk("arst_rem", 64'(remaining), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    check_ops_mem();
    run_xfer(32'h180, 32'h280, 2, 1'b0, 0, 0);

    // Randomised transfers
    for (int t = 0; t < 30; t++) begin
      int r;
      bm  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      r   = $urandom_range(0, 9);
      src = 32'($urandom_range(0, 'h7E0));
      dst = 32'($urandom_range(0, 'h7E0));
      if (r == 7 || r == 8) dst = LIMIT - 32'($urandom_range(1, 32));
      if (r == 9) src = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (!bm && $urandom_range(0, 4) != 0) begin
        src[1:0] = 2'b00;
        dst[1:0] = 2'b00;
      end
      abt = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(1, 2 * len + 1) : 0;
      inj = (abt == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_xfer(src, dst, len, bm, inj, abt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
